snake_vga_timing: RTL and testbench

//  VGA timing generator and pixel sink for the snake game's display path. Runs h/v counters,

---
 rtl/snake_vga_pkg.sv | 49 ++++
 rtl/snake_vga_counter.sv | 33 +++
 rtl/snake_vga_timing.sv | 131 +++++++++++++
 tb/tb_snake_vga_timing.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_vga_pkg.sv
// snake_vga_pkg
//   Shared definitions for the snake game VGA display path:
//     - default 640x480@60 timing (sync / back porch / active / front porch)
//     - helper to derive line/frame totals from the four timing segments
//     - RGB565 colour constants and the test-pattern bar colour table
package snake_vga_pkg;

   localparam int CNT_W = 11;

   localparam int DEF_H_SYNC  = 96;
   localparam int DEF_H_BACK  = 48;
   localparam int DEF_H_DISP  = 640;
   localparam int DEF_H_FRONT = 16;
   localparam int DEF_V_SYNC  = 2;
   localparam int DEF_V_BACK  = 33;
   localparam int DEF_V_DISP  = 480;
   localparam int DEF_V_FRONT = 10;

   typedef logic [15:0] rgb565_t;

   localparam rgb565_t COLOR_WHITE   = 16'hFFFF;
   localparam rgb565_t COLOR_YELLOW  = 16'hFFE0;
   localparam rgb565_t COLOR_CYAN    = 16'h07FF;
   localparam rgb565_t COLOR_GREEN   = 16'h07E0;
   localparam rgb565_t COLOR_MAGENTA = 16'hF81F;
   localparam rgb565_t COLOR_RED     = 16'hF800;
   localparam rgb565_t COLOR_BLUE    = 16'h001F;
   localparam rgb565_t COLOR_BLACK   = 16'h0000;

   function automatic int span_total(input int sync_w, input int back_w,
                                     input int disp_w, input int front_w);
      return sync_w + back_w + disp_w + front_w;
   endfunction

   // Test-pattern bars, left to right.
   function automatic rgb565_t bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return COLOR_WHITE;
         3'd1:    return COLOR_YELLOW;
         3'd2:    return COLOR_CYAN;
         3'd3:    return COLOR_GREEN;
         3'd4:    return COLOR_MAGENTA;
         3'd5:    return COLOR_RED;
         3'd6:    return COLOR_BLUE;
         default: return COLOR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/snake_vga_counter.sv
// snake_vga_counter
//   Generic wrap counter: counts 0..MAX, advancing on en, returning to 0
//   after MAX.
//   Ports:
//     clk   in   clock
//     rstn  in   asynchronous active-low reset (count -> 0)
//     en    in   advance enable
//     cnt   out  current count (W bits)
//     wrap  out  en && cnt==MAX, i.e. the count returns to 0 on this edge
module snake_vga_counter #(
   parameter int W   = 11,
   parameter int MAX = 799
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   assign wrap = en && (cnt == W'(MAX));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/snake_vga_timing.sv
// snake_vga_timing
//   VGA timing generator and pixel sink. Runs the h/v counters, drives the
//   active-low syncs, requests pixel coordinates one clock ahead of display
//   and passes the renderer's registered RGB565 back out, blanked outside
//   the active window.
//   Ports:
//     clk          in   pixel clock
//     rstn         in   asynchronous active-low reset
//     test_en      in   colour-bar test pattern select (VGA_TEST_PATTERN_EN only)
//     pixel_data   in   RGB565 from renderer, 1 clk after its xpos/ypos
//     pixel_xpos   out  requested column (0 when pixel_req low)
//     pixel_ypos   out  requested row (0 when pixel_req low)
//     pixel_req    out  xpos/ypos valid
//     vga_hs       out  hsync, active-low
//     vga_vs       out  vsync, active-low
//     vga_de       out  active-video enable
//     vga_rgb      out  RGB565 to DAC
//     frame_start  out  1-clk pulse once per frame, the clk after (0,0)
//   Build option: define VGA_TEST_PATTERN_EN to add test_en and the
//   8-bar colour pattern.
module snake_vga_timing
   import snake_vga_pkg::*;
#(
   parameter int H_SYNC  = DEF_H_SYNC,
   parameter int H_BACK  = DEF_H_BACK,
   parameter int H_DISP  = DEF_H_DISP,
   parameter int H_FRONT = DEF_H_FRONT,
   parameter int V_SYNC  = DEF_V_SYNC,
   parameter int V_BACK  = DEF_V_BACK,
   parameter int V_DISP  = DEF_V_DISP,
   parameter int V_FRONT = DEF_V_FRONT
) (
   input  logic             clk,
   input  logic             rstn,
`ifdef VGA_TEST_PATTERN_EN
   input  logic             test_en,
`endif
   input  logic [15:0]      pixel_data,
   output logic [CNT_W-1:0] pixel_xpos,
   output logic [CNT_W-1:0] pixel_ypos,
   output logic             pixel_req,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_de,
   output logic [15:0]      vga_rgb,
   output logic             frame_start
);

   localparam int H_TOTAL = span_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
   localparam int V_TOTAL = span_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
   localparam int HA      = H_SYNC + H_BACK;
   localparam int VA      = V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] REQ_X0  = CNT_W'(HA - 1);
   localparam logic [CNT_W-1:0] REQ_X1  = CNT_W'(HA + H_DISP - 1);
   localparam logic [CNT_W-1:0] ACT_Y0  = CNT_W'(VA);
   localparam logic [CNT_W-1:0] ACT_Y1  = CNT_W'(VA + V_DISP);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             at_origin;
   logic             req_h;
   logic             req_v;

   snake_vga_counter #(.W(CNT_W), .MAX(H_TOTAL - 1)) u_h_cnt (
      .clk  (clk),
      .rstn (rstn),
      .en   (1'b1),
      .cnt  (h_cnt),
      .wrap (h_wrap)
   );

   snake_vga_counter #(.W(CNT_W), .MAX(V_TOTAL - 1)) u_v_cnt (
      .clk  (clk),
      .rstn (rstn),
      .en   (h_wrap),
      .cnt  (v_cnt),
      .wrap (v_wrap)
   );

   assign vga_hs = (h_cnt >= HS_END);
   assign vga_vs = (v_cnt >= VS_END);

   // Requests lead the displayed pixel by one clock to cover the renderer's
   // output register.
   assign req_h      = (h_cnt >= REQ_X0) && (h_cnt < REQ_X1);
   assign req_v      = (v_cnt >= ACT_Y0) && (v_cnt < ACT_Y1);
   assign pixel_req  = req_h && req_v;
   assign pixel_xpos = pixel_req ? (h_cnt - REQ_X0) : '0;
   assign pixel_ypos = pixel_req ? (v_cnt - ACT_Y0) : '0;

   // at_origin tracks "counters are at (0,0)" without a full compare: true
   // out of reset and after each simultaneous h/v wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vga_de      <= 1'b0;
         at_origin   <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         vga_de      <= pixel_req;
         at_origin   <= h_wrap && v_wrap;
         frame_start <= at_origin;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [CNT_W-1:0] act_x;
   logic [CNT_W-1:0] bar_full;
   logic [2:0]       bar_idx;

   // Only meaningful while vga_de is high; the blanking mux hides the
   // wrapped-around values elsewhere.
   assign act_x    = h_cnt - CNT_W'(HA);
   assign bar_full = act_x >> 6;
   assign bar_idx  = (bar_full > CNT_W'(7)) ? 3'd7 : bar_full[2:0];

   always_comb begin
      vga_rgb = COLOR_BLACK;
      if (vga_de) begin
         vga_rgb = test_en ? bar_color(bar_idx) : pixel_data;
      end
   end
`else
   assign vga_rgb = vga_de ? pixel_data : COLOR_BLACK;
`endif

endmodule

// File: tb/tb_snake_vga_timing.sv
module tb_snake_vga_timing;

   localparam int S_HS = 5, S_HB = 4, S_HD = 20, S_HF = 3;
   localparam int S_VS = 2, S_VB = 2, S_VD = 6,  S_VF = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] b_pd = '0, s_pd = '0;
   logic [10:0] b_xpos, b_ypos, s_xpos, s_ypos;
   logic        b_req, b_hs, b_vs, b_de, b_fs;
   logic        s_req, s_hs, s_vs, s_de, s_fs;
   logic [15:0] b_rgb, s_rgb;
`ifdef VGA_TEST_PATTERN_EN
   logic        test_en = 1'b0;
`endif

   snake_vga_timing u_big (
      .clk(clk), .rstn(rstn),
`ifdef VGA_TEST_PATTERN_EN
      .test_en(test_en),
`endif
      .pixel_data(b_pd), .pixel_xpos(b_xpos), .pixel_ypos(b_ypos),
      .pixel_req(b_req), .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de),
      .vga_rgb(b_rgb), .frame_start(b_fs)
   );

   snake_vga_timing #(
      .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
      .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF)
   ) u_small (
      .clk(clk), .rstn(rstn),
`ifdef VGA_TEST_PATTERN_EN
      .test_en(test_en),
`endif
      .pixel_data(s_pd), .pixel_xpos(s_xpos), .pixel_ypos(s_ypos),
      .pixel_req(s_req), .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de),
      .vga_rgb(s_rgb), .frame_start(s_fs)
   );

   // Renderers: one-clock registered colour = x + y*width, garbage when idle.
   always @(posedge clk) begin
      b_pd <= b_req ? 16'(int'(b_xpos) + int'(b_ypos) * 640) : 16'($urandom);
      s_pd <= s_req ? 16'(int'(s_xpos) + int'(s_ypos) * S_HD) : 16'($urandom);
   end

   // Clock edges seen since reset was last released.
   int t = 0;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) t <= 0;
      else       t <= t + 1;
   end

   int bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                   16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   typedef struct {
      bit hs, vs, req, de, fs;
      int xpos, ypos, rgb;
   } exp_t;

   function automatic exp_t model(int tt, int hsy, int hb, int hd, int hf,
                                  int vsy, int vb, int vd, int vf, bit ten);
      exp_t e;
      int htot = hsy + hb + hd + hf;
      int vtot = vsy + vb + vd + vf;
      int ha = hsy + hb;
      int va = vsy + vb;
      int h = tt % htot;
      int v = (tt / htot) % vtot;
      bit vact = (v >= va) && (v < va + vd);
      int bi;
      e.hs   = (h >= hsy);
      e.vs   = (v >= vsy);
      e.req  = (h >= ha - 1) && (h < ha + hd - 1) && vact;
      e.xpos = e.req ? h - (ha - 1) : 0;
      e.ypos = e.req ? v - va : 0;
      e.de   = (h >= ha) && (h < ha + hd) && vact;
      e.fs   = (tt >= 1) && (((tt - 1) % (htot * vtot)) == 0);
      e.rgb  = 0;
      if (e.de) begin
         bi = (h - ha) / 64;
         if (bi > 7) bi = 7;
         e.rgb = ten ? bars[bi] : (((h - ha) + (v - va) * hd) % 65536);
      end
      return e;
   endfunction

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         if (fails <= 30)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, expv, t);
      end
   endtask

   bit meas = 0;
   int hs_low_l1 = 0, vs_low = 0, req_l35 = 0, fs_big = 0;

   always @(negedge clk) begin : cmp
      exp_t eb, es;
      bit ten;
      ten = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
      ten = test_en;
`endif
      eb = model(t, 96, 48, 640, 16, 2, 33, 480, 10, ten);
      es = model(t, S_HS, S_HB, S_HD, S_HF, S_VS, S_VB, S_VD, S_VF, ten);
      chk("big.hs",   32'(b_hs),   32'(eb.hs));
      chk("big.vs",   32'(b_vs),   32'(eb.vs));
      chk("big.req",  32'(b_req),  32'(eb.req));
      chk("big.xpos", 32'(b_xpos), eb.xpos);
      chk("big.ypos", 32'(b_ypos), eb.ypos);
      chk("big.de",   32'(b_de),   32'(eb.de));
      chk("big.fs",   32'(b_fs),   32'(eb.fs));
      chk("big.rgb",  32'(b_rgb),  eb.rgb);
      chk("small.hs",   32'(s_hs),   32'(es.hs));
      chk("small.vs",   32'(s_vs),   32'(es.vs));
      chk("small.req",  32'(s_req),  32'(es.req));
      chk("small.xpos", 32'(s_xpos), es.xpos);
      chk("small.ypos", 32'(s_ypos), es.ypos);
      chk("small.de",   32'(s_de),   32'(es.de));
      chk("small.fs",   32'(s_fs),   32'(es.fs));
      chk("small.rgb",  32'(s_rgb),  es.rgb);
      if (meas) begin
         if (t >= 800 && t < 1600 && !b_hs) hs_low_l1++;
         if (t >= 1 && t <= 2000 && !b_vs) vs_low++;
         if (t >= 28000 && t < 28800 && b_req) req_l35++;
         if (b_fs) fs_big++;
      end
   end

   task automatic wait_t(input int n);
      do @(negedge clk); while (t < n);
      chk("wait_t", t, n);
   endtask

   task automatic chk_big_zero(input string tag);
      chk({tag, ".hs"},   32'(b_hs),   0);
      chk({tag, ".vs"},   32'(b_vs),   0);
      chk({tag, ".de"},   32'(b_de),   0);
      chk({tag, ".rgb"},  32'(b_rgb),  0);
      chk({tag, ".req"},  32'(b_req),  0);
      chk({tag, ".xpos"}, 32'(b_xpos), 0);
      chk({tag, ".ypos"}, 32'(b_ypos), 0);
      chk({tag, ".fs"},   32'(b_fs),   0);
   endtask

`ifdef VGA_TEST_PATTERN_EN
   bit done = 0;
   initial begin
      while (!done) begin
         @(posedge clk);
         #1;
         if (!meas || t < 27000)
            test_en = ($urandom_range(0, 99) == 0) ? ~test_en : test_en;
         else if (t < 28790) test_en = 1'b0;
         else if (t < 29600) test_en = 1'b1;
         else if (t < 29900) test_en = ($urandom_range(0, 49) == 0) ? ~test_en : test_en;
         else test_en = 1'b0;
      end
   end
`endif

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rnd;
      repeat (10) @(posedge clk);
      #1 chk_big_zero("in_reset");
      @(negedge clk);
      #2 rstn = 1'b1;

      // Random asynchronous reset pulse somewhere in the first frame.
      rnd = $urandom_range(500, 2500);
      wait_t(rnd);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1 chk_big_zero("early_rst");
      repeat ($urandom_range(1, 5)) @(posedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;
      meas = 1;

      wait_t(95);   chk("hs_before_96", 32'(b_hs), 0);
      wait_t(96);   chk("hs_at_96", 32'(b_hs), 1);
      wait_t(1599); chk("vs_before_1600", 32'(b_vs), 0);
      wait_t(1600); chk("vs_at_1600", 32'(b_vs), 1);
      chk("hs_low_per_line", hs_low_l1, 96);
      // t=0 is not sampled, so 1599 of the 1600 vsync-low clocks fall in [1,2000].
      wait_t(2001); chk("vs_low_count", vs_low, 1599);

      wait_t(28143); chk("l35_first_req", 32'(b_req), 1);
                     chk("l35_first_x", 32'(b_xpos), 0);
                     chk("l35_ypos", 32'(b_ypos), 0);
      wait_t(28144); chk("l35_rgb_first", 32'(b_rgb), 0);
                     chk("l35_de_first", 32'(b_de), 1);
      wait_t(28782); chk("l35_last_req", 32'(b_req), 1);
                     chk("l35_last_x", 32'(b_xpos), 639);
      wait_t(28783); chk("l35_req_off", 32'(b_req), 0);
                     chk("l35_rgb_last", 32'(b_rgb), 639);
      wait_t(28784); chk("l35_rgb_blank", 32'(b_rgb), 0);
                     chk("l35_de_off", 32'(b_de), 0);
      wait_t(28800); chk("l35_req_count", req_l35, 640);
`ifdef VGA_TEST_PATTERN_EN
      wait_t(28944); chk("bar_x0", 32'(b_rgb), 32'h0000FFFF);
      wait_t(29264); chk("bar_x320", 32'(b_rgb), 32'h0000F800);
      wait_t(29583); chk("bar_x639", 32'(b_rgb), 32'h00000000);
`else
      wait_t(28944); chk("l36_rgb_x0", 32'(b_rgb), 640);
      wait_t(29583); chk("l36_rgb_x639", 32'(b_rgb), 1279);
`endif

      // Mid-line reset at line 37, h_cnt=400.
      wait_t(30000);
      meas = 0;
      chk("fs_per_frame", fs_big, 1);
      chk("hs_before_midrst", 32'(b_hs), 1);
      #2 rstn = 1'b0;
      #1 chk_big_zero("mid_rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;
      wait_t(1); chk("restart_fs", 32'(b_fs), 1);
                 chk("restart_hs", 32'(b_hs), 0);
      wait_t(2); chk("restart_fs_off", 32'(b_fs), 0);
      wait_t(3000);

`ifdef VGA_TEST_PATTERN_EN
      done = 1;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
